exec_arith_branch: RTL and testbench

EXEC_ARITH_BRANCH -- requirements
Module: exec_arith_branch

---
 rtl/exec_arith_branch.sv | 139 +++++++++++++
 tb/tb_exec_arith_branch.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/exec_arith_branch.sv
// Execute stage: add/sub with carry, optional abs, flag register, branch resolve.
// Optional abs-value unit is enabled by defining EXEC_ARITH_ABSX_EN.
module exec_arith_branch #(
   parameter int W_OPR = 32,
   parameter int ADDR  = 16,
   parameter int W_IMM = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v_i,
   input  logic             stall_i,
   input  logic [1:0]       op_i,
   input  logic [1:0]       sel_i,
   input  logic [3:0]       cc_i,
   input  logic             immf_i,
   input  logic             sign_i,
   input  logic [W_IMM-1:0] imm_i,
   input  logic [W_OPR-1:0] opr0_i,
   input  logic [W_OPR-1:0] opr1_i,
   input  logic [ADDR-1:0]  pc_i,
   output logic             v_o,
   output logic [W_OPR-1:0] result_o,
   output logic [3:0]       flags_o,
   output logic             stall_o,
   output logic             branch_o,
   output logic [ADDR-1:0]  branch_addr_o
);

   localparam logic [1:0] OP_ADDX = 2'd0;
   localparam logic [1:0] OP_ABSX = 2'd1;
   localparam logic [1:0] OP_BR   = 2'd2;
   localparam int         M       = W_OPR - 1;

   logic [W_OPR-1:0] b_opr;
   logic             accept;
   logic             cin;
   logic [W_OPR:0]   wide;
   logic [W_OPR-1:0] add_res;
   logic             add_v;
   logic [W_OPR-1:0] nxt_res;
   logic [3:0]       nxt_flags;
   logic             upd_flags;
   logic             cond;
   logic             fv, fs, fz, fc;

   assign {fv, fs, fz, fc} = flags_o;
   assign stall_o = stall_i;
   assign accept  = v_i & (~stall_i | ~v_o);

   always_comb begin
      b_opr = opr1_i;
      if (immf_i) begin
         if (sign_i)
            b_opr = {{(W_OPR-W_IMM){imm_i[W_IMM-1]}}, imm_i};
         else
            b_opr = {{(W_OPR-W_IMM){1'b0}}, imm_i};
      end
   end

   // Subtract path yields the borrow directly in the top bit.
   assign cin = sel_i[0] & fc;
   always_comb begin
      if (sel_i[1])
         wide = {1'b0, opr0_i} - {1'b0, b_opr} - {{W_OPR{1'b0}}, cin};
      else
         wide = {1'b0, opr0_i} + {1'b0, b_opr} + {{W_OPR{1'b0}}, cin};
   end
   assign add_res = wide[W_OPR-1:0];
   assign add_v   = ((opr0_i[M] ^ b_opr[M]) == sel_i[1])
                  & (add_res[M] != opr0_i[M]);

`ifdef EXEC_ARITH_ABSX_EN
   logic [W_OPR-1:0] abs_res;
   assign abs_res = b_opr[M] ? (~b_opr + 1'b1) : b_opr;
`endif

   always_comb begin
      nxt_res   = '0;
      nxt_flags = flags_o;
      upd_flags = 1'b0;
      unique case (1'b1)
         (op_i == OP_ADDX): begin
            nxt_res   = add_res;
            nxt_flags = {add_v, add_res[M], add_res == '0, wide[W_OPR]};
            upd_flags = 1'b1;
         end
`ifdef EXEC_ARITH_ABSX_EN
         (op_i == OP_ABSX): begin
            nxt_res   = abs_res;
            nxt_flags = {abs_res[M], abs_res[M], b_opr == '0, 1'b0};
            upd_flags = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (cc_i)
         4'd0:  cond = 1'b1;
         4'd1:  cond = fz;
         4'd2:  cond = ~fz;
         4'd3:  cond = fc;
         4'd4:  cond = ~fc;
         4'd5:  cond = fs;
         4'd6:  cond = ~fs;
         4'd7:  cond = fv;
         4'd8:  cond = ~fv;
         4'd9:  cond = ~fc & ~fz;
         4'd10: cond = fc | fz;
         4'd11: cond = (fs == fv);
         4'd12: cond = (fs != fv);
         4'd13: cond = ~fz & (fs == fv);
         4'd14: cond = fz | (fs != fv);
         default: cond = 1'b0;
      endcase
   end

   assign branch_o      = ~reset & accept & (op_i == OP_BR) & cond;
   assign branch_addr_o = sel_i[0] ? pc_i + b_opr[ADDR-1:0]
                                   : b_opr[ADDR-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         v_o      <= 1'b0;
         result_o <= '0;
         flags_o  <= '0;
      end else if (accept) begin
         v_o      <= 1'b1;
         result_o <= nxt_res;
         if (upd_flags)
            flags_o <= nxt_flags;
      end else if (!stall_i) begin
         v_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exec_arith_branch.sv
// Self-checking bench: directed vectors plus random traffic against a
// behavioural model of the execute stage.
module tb_exec_arith_branch;

   logic        clk = 1'b0;
   logic        reset;
   logic        v_i, stall_i, immf_i, sign_i;
   logic [1:0]  op_i, sel_i;
   logic [3:0]  cc_i;
   logic [15:0] imm_i, pc_i;
   logic [31:0] opr0_i, opr1_i;
   logic        v_o, stall_o, branch_o;
   logic [31:0] result_o;
   logic [3:0]  flags_o;
   logic [15:0] branch_addr_o;

   int checks = 0;
   int errors = 0;

   logic        mv;
   logic [31:0] mres;
   logic [3:0]  mflags;
   logic        obs_br;
   logic [15:0] obs_addr;

   exec_arith_branch dut (
      .clk(clk), .reset(reset), .v_i(v_i), .stall_i(stall_i),
      .op_i(op_i), .sel_i(sel_i), .cc_i(cc_i), .immf_i(immf_i),
      .sign_i(sign_i), .imm_i(imm_i), .opr0_i(opr0_i), .opr1_i(opr1_i),
      .pc_i(pc_i), .v_o(v_o), .result_o(result_o), .flags_o(flags_o),
      .stall_o(stall_o), .branch_o(branch_o),
      .branch_addr_o(branch_addr_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set(bit v, bit st, logic [1:0] op, logic [1:0] sel,
                      logic [3:0] cc, bit immf, bit sgn, logic [15:0] imm,
                      logic [31:0] a, logic [31:0] b, logic [15:0] pc);
      v_i = v; stall_i = st; op_i = op; sel_i = sel; cc_i = cc;
      immf_i = immf; sign_i = sgn; imm_i = imm;
      opr0_i = a; opr1_i = b; pc_i = pc;
   endtask

   task automatic cycle();
      longint ua, ub, sa, sb, t, sv;
      logic [31:0] b32, r;
      bit z, c, s, v, cond, acc, exp_br, cn;
      logic [15:0] exp_addr;
      {v, s, z, c} = mflags;
      if (immf_i)
         ub = sign_i ? longint'($signed(imm_i)) : longint'(imm_i);
      else
         ub = longint'(opr1_i);
      b32 = ub[31:0];
      ub  = longint'(b32);
      ua  = longint'(opr0_i);
      sa  = longint'($signed(opr0_i));
      sb  = longint'($signed(b32));
      case (int'(cc_i))
         0: cond = 1;       1: cond = z;      2: cond = !z;
         3: cond = c;       4: cond = !c;     5: cond = s;
         6: cond = !s;      7: cond = v;      8: cond = !v;
         9: cond = !c && !z;               10: cond = c || z;
         11: cond = s == v;                 12: cond = s != v;
         13: cond = !z && s == v;           14: cond = z || s != v;
         default: cond = 0;
      endcase
      acc      = v_i && (!stall_i || !mv);
      exp_br   = !reset && acc && op_i == 2 && cond;
      exp_addr = sel_i[0] ? 16'((pc_i + ub) % 65536) : 16'(ub % 65536);
      #1;
      obs_br   = branch_o;
      obs_addr = branch_addr_o;
      chk("branch_o", 32'(branch_o), 32'(exp_br));
      chk("stall_o", 32'(stall_o), 32'(stall_i));
      if (exp_br)
         chk("branch_addr", 32'(branch_addr_o), 32'(exp_addr));
      if (reset) begin
         mv = 0; mres = 0; mflags = 0;
      end else if (acc) begin
         mv = 1;
         mres = 0;
         if (op_i == 0) begin
            cn = sel_i[0] && c;
            if (sel_i[1]) begin
               t  = ua - ub - cn;
               c  = ua < ub + cn;
               sv = sa - sb - cn;
            end else begin
               t  = ua + ub + cn;
               c  = t >= 64'h1_0000_0000;
               sv = sa + sb + cn;
            end
            r = t[31:0];
            v = sv > 64'sd2147483647 || sv < -64'sd2147483648;
            mres = r;
            mflags = {v, r[31], r == 0, c};
         end
`ifdef EXEC_ARITH_ABSX_EN
         else if (op_i == 1) begin
            t = sb < 0 ? -sb : sb;
            r = t[31:0];
            mres = r;
            mflags = {b32 == 32'h8000_0000, r[31], b32 == 0, 1'b0};
         end
`endif
      end else if (!stall_i) begin
         mv = 0;
      end
      @(posedge clk);
      #1;
      chk("v_o", 32'(v_o), 32'(mv));
      chk("result_o", result_o, mres);
      chk("flags_o", 32'(flags_o), 32'(mflags));
   endtask

   initial begin
      mv = 0; mres = 0; mflags = 0;
      reset = 1;
      set(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      cycle();
      chk("rst_v", 32'(v_o), 0);
      chk("rst_res", result_o, 0);
      chk("rst_flags", 32'(flags_o), 0);
      reset = 0;

      set(1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0);
      cycle();
      chk("add_wrap_res", result_o, 0);
      chk("add_wrap_flags", 32'(flags_o), 4'b0011);

      set(1, 0, 0, 0, 0, 0, 0, 0, 32'h7FFF_FFFF, 1, 0);
      cycle();
      chk("add_ovf_res", result_o, 32'h8000_0000);
      chk("add_ovf_flags", 32'(flags_o), 4'b1100);
      set(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("adc_res", result_o, 0);
      chk("adc_flags", 32'(flags_o), 4'b0010);

      set(1, 0, 2, 1, 1, 1, 1, 16'hFFF0, 0, 0, 16'h0100);
      cycle();
      chk("br_z_taken", 32'(obs_br), 1);
      chk("br_z_addr", 32'(obs_addr), 32'h00F0);
      chk("br_res", result_o, 0);
      set(1, 0, 2, 1, 2, 1, 1, 16'hFFF0, 0, 0, 16'h0100);
      cycle();
      chk("br_nz_nottaken", 32'(obs_br), 0);

      set(1, 0, 0, 2, 0, 1, 1, 16'h0002, 1, 0, 0);
      cycle();
      chk("sub_imm_res", result_o, 32'hFFFF_FFFF);
      chk("sub_imm_flags", 32'(flags_o), 4'b0101);

      set(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFB, 0);
      cycle();
`ifdef EXEC_ARITH_ABSX_EN
      chk("abs_res", result_o, 5);
      chk("abs_flags", 32'(flags_o), 4'b0000);
`else
      chk("absnop_res", result_o, 0);
      chk("absnop_flags", 32'(flags_o), 4'b0101);
`endif
      set(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h8000_0000, 0);
      cycle();
`ifdef EXEC_ARITH_ABSX_EN
      chk("absmin_res", result_o, 32'h8000_0000);
      chk("absmin_flags", 32'(flags_o), 4'b1100);
`else
      chk("absnop_v", 32'(v_o), 1);
`endif

      set(1, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0);
      cycle();
      for (int i = 0; i < 3; i++) begin
         set(1, 1, 0, 0, 0, 0, 0, 0, 10, 10, 0);
         cycle();
         chk("stall_hold_res", result_o, 5);
         chk("stall_hold_v", 32'(v_o), 1);
      end
      set(1, 0, 0, 0, 0, 0, 0, 0, 10, 10, 0);
      cycle();
      chk("stall_release", result_o, 20);
      set(1, 1, 0, 0, 0, 0, 0, 0, 7, 7, 0);
      cycle();
      reset = 1;
      cycle();
      chk("rst_mid_v", 32'(v_o), 0);
      chk("rst_mid_res", result_o, 0);
      chk("rst_mid_flags", 32'(flags_o), 0);
      reset = 0;

      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         set($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
             2'($urandom), 2'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 16'($urandom),
             $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom,
             $urandom_range(0, 3) == 0 ? 32'h8000_0000 : $urandom,
             16'($urandom));
         cycle();
      end
      reset = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
